// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage divider: op encodings, FSM state
// encoding and small op-decode helpers.
package alu_pkg;

  localparam int W = 32;

  // RV32M divide-family operation select
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  // Divider FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // DIV and REM treat their operands as two's complement
  function automatic logic is_signed_op(input logic [1:0] op);
    return !(op inside {OP_DIVU, OP_REMU});
  endfunction

  // REM and REMU return the remainder instead of the quotient
  function automatic logic is_rem_op(input logic [1:0] op);
    return op inside {OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/carry_lookahead_adder.sv
// Generic N-bit adder with carry-in, used for the divider's trial subtraction.
module carry_lookahead_adder #(
  parameter int N = 33
) (
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         in_cin,
  output logic [N-1:0] sum
);

  logic [N-1:0] gen;
  logic [N-1:0] prop;
  logic [N-1:0] carry;

  // Generate/propagate terms and the carry into every bit position
  always_comb begin
    gen      = in_a & in_b;
    prop     = in_a ^ in_b;
    carry    = '0;
    carry[0] = in_cin;
    for (int i = 0; i < N - 1; i++) begin
      carry[i+1] = gen[i] | (prop[i] & carry[i]);
    end
    sum = prop ^ carry;
  end

endmodule

// File: rtl/alu_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU. One quotient bit
// per cycle, then one cycle of sign correction, then a held result.
module alu_div_unit
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_lhs,
  input  logic [W-1:0] in_rhs,
  input  logic [1:0]   div_op,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] div_result,
  output logic         busy
);

  localparam int            CW      = $clog2(W);
  localparam logic [CW-1:0] LAST    = CW'(W - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [W-1:0]  ONE     = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]  MIN_NEG = {1'b1, {(W-1){1'b0}}};

  logic [1:0]    state;
  logic [CW-1:0] count;
  // The top bit of the W+1-bit partial remainder is always zero between
  // iterations (a kept trial result is below the divisor), so only W bits
  // are stored; the full W+1-bit value is {rem_r, quo_r[W-1]} at trial time.
  logic [W-1:0]  rem_r;
  logic [W-1:0]  quo_r;
  logic [W-1:0]  divisor;
  logic [1:0]    op_r;
  logic          neg_q;
  logic          neg_r;

  logic [W:0]    trial;
  logic          accept;
  logic          acc_signed;
  logic          acc_div_zero;
  logic          acc_overflow;
  logic [W-1:0]  abs_lhs;
  logic [W-1:0]  abs_rhs;
  logic [W-1:0]  fix_sel;
  logic          fix_neg;
  logic [W-1:0]  fix_val;

  assign in_ready = rst_n && (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);
  assign accept   = in_valid && in_ready && !flush;

  // Trial subtract: {R, next dividend bit} - divisor as add of the inverse plus one
  carry_lookahead_adder #(.N(W + 1)) u_trial (
    .in_a   ({rem_r, quo_r[W-1]}),
    .in_b   (~{1'b0, divisor}),
    .in_cin (1'b1),
    .sum    (trial)
  );

  // Operand decode at accept: magnitudes and the two special cases
  always_comb begin
    acc_signed   = is_signed_op(div_op);
    abs_lhs      = (acc_signed && in_lhs[W-1]) ? (~in_lhs + ONE) : in_lhs;
    abs_rhs      = (acc_signed && in_rhs[W-1]) ? (~in_rhs + ONE) : in_rhs;
    acc_div_zero = (in_rhs == '0);
    acc_overflow = acc_signed && (in_lhs == MIN_NEG) && (in_rhs == '1);
  end

  // Final sign correction: pick quotient or remainder and negate it if needed
  always_comb begin
    fix_sel = is_rem_op(op_r) ? rem_r : quo_r;
    fix_neg = is_rem_op(op_r) ? neg_r : neg_q;
    fix_val = fix_neg ? (~fix_sel + ONE) : fix_sel;
  end

  // Control FSM and datapath registers; flush wins over every handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      count      <= '0;
      rem_r      <= '0;
      quo_r      <= '0;
      divisor    <= '0;
      op_r       <= OP_DIV;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      div_result <= '0;
      out_valid  <= 1'b0;
    end else if (flush) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_r    <= div_op;
            neg_q   <= acc_signed && (in_lhs[W-1] ^ in_rhs[W-1]);
            neg_r   <= acc_signed && in_lhs[W-1];
            divisor <= abs_rhs;
            quo_r   <= abs_lhs;
            rem_r   <= '0;
            count   <= LAST;
            if (acc_div_zero) begin
              div_result <= is_rem_op(div_op) ? in_lhs : '1;
              out_valid  <= 1'b1;
              state      <= ST_DONE;
            end else if (acc_overflow) begin
              div_result <= is_rem_op(div_op) ? '0 : MIN_NEG;
              out_valid  <= 1'b1;
              state      <= ST_DONE;
            end else begin
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          rem_r <= trial[W] ? {rem_r[W-2:0], quo_r[W-1]} : trial[W-1:0];
          quo_r <= {quo_r[W-2:0], ~trial[W]};
          if (count == '0) begin
            state <= ST_FIX;
          end else begin
            count <= count - CNT_ONE;
          end
        end
        ST_FIX: begin
          div_result <= fix_val;
          out_valid  <= 1'b1;
          state      <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_unit.sv
// Self-checking bench for alu_div_unit: directed test-plan cases with literal
// expectations plus a long randomized run against a cycle-level reference.
module tb_alu_div_unit;
  import alu_pkg::*;

  localparam int LAT_NORMAL  = W + 1;
  localparam int LAT_SPECIAL = 0;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_lhs = '0;
  logic [W-1:0] in_rhs = '0;
  logic [1:0]   div_op = OP_DIV;
  logic         flush = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] div_result;
  logic         busy;

  int checks = 0;
  int errors = 0;

  bit           m_running = 1'b0;
  bit           m_valid = 1'b0;
  int           m_cnt = 0;
  logic [W-1:0] m_result = '0;
  logic [W-1:0] m_pending = '0;
  bit           compare_on = 1'b0;

  always #5 clk = ~clk;

  alu_div_unit #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_lhs     (in_lhs),
    .in_rhs     (in_rhs),
    .div_op     (div_op),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .div_result (div_result),
    .busy       (busy)
  );

  // RISC-V divide semantics written directly from the instruction rules
  function automatic logic [W-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int sa;
    int sb;
    bit rem_sel;
    bit sgn;
    rem_sel = (op == OP_REM) || (op == OP_REMU);
    sgn     = (op == OP_DIV) || (op == OP_REM);
    sa = int'(a);
    sb = int'(b);
    if (b == 0) return rem_sel ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem_sel ? 32'h0 : 32'h8000_0000;
    if (sgn) return rem_sel ? 32'(sa % sb) : 32'(sa / sb);
    return rem_sel ? (a % b) : (a / b);
  endfunction

  function automatic bit ref_special(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit sgn;
    sgn = (op == OP_DIV) || (op == OP_REM);
    return (b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: advances on every rising edge from the sampled inputs
  always @(posedge clk) begin
    if (!rst_n) begin
      m_running  = 1'b0;
      m_valid    = 1'b0;
      m_cnt      = 0;
      m_result   = '0;
      compare_on = 1'b1;
    end else if (flush) begin
      m_running = 1'b0;
      m_valid   = 1'b0;
    end else if (m_valid) begin
      if (out_ready) m_valid = 1'b0;
    end else if (m_running) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_running = 1'b0;
        m_valid   = 1'b1;
        m_result  = m_pending;
      end
    end else if (in_valid) begin
      if (ref_special(div_op, in_lhs, in_rhs)) begin
        m_valid  = 1'b1;
        m_result = ref_result(div_op, in_lhs, in_rhs);
      end else begin
        m_running = 1'b1;
        m_cnt     = LAT_NORMAL;
        m_pending = ref_result(div_op, in_lhs, in_rhs);
      end
    end
  end

  // Every-cycle comparison of all outputs against the reference model
  always @(negedge clk) begin
    if (compare_on) begin
      checkOutput("cyc_out_valid", 32'(out_valid), 32'(m_valid));
      checkOutput("cyc_div_result", div_result, m_result);
      checkOutput("cyc_in_ready", 32'(in_ready), 32'(rst_n && !m_running && !m_valid));
      checkOutput("cyc_busy", 32'(busy), 32'(m_running || m_valid));
    end
  end

  task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    checkOutput("accept_ready", 32'(in_ready), 32'd1);
    div_op   = op;
    in_lhs   = a;
    in_rhs   = b;
    in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    in_lhs   = $urandom;
    in_rhs   = $urandom;
  endtask

  task automatic waitResult(input string name, output int lat);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    checkOutput({name, "_valid"}, 32'(out_valid), 32'd1);
    lat = n;
  endtask

  task automatic runOp(input string name, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] expected, input int exp_lat);
    int lat;
    applyStimulus(op, a, b);
    waitResult(name, lat);
    checkOutput(name, div_result, expected);
    checkOutput({name, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    logic [W-1:0] held;
    int           lat;
    bit           seen;

    $display("[TB] start");
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_div_result", div_result, 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("release_in_ready", 32'(in_ready), 32'd1);

    // Directed cases; latency counts edges after the accept edge before
    // out_valid is registered high (special cases register on the accept edge)
    runOp("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, LAT_NORMAL);
    runOp("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, LAT_NORMAL);
    runOp("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT_NORMAL);
    runOp("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT_NORMAL);
    runOp("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, LAT_NORMAL);
    runOp("divu_5_0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_SPECIAL);
    runOp("remu_5_0", OP_REMU, 32'd5, 32'd0, 32'd5, LAT_SPECIAL);
    runOp("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SPECIAL);
    runOp("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT_SPECIAL);

    // Backpressure in DONE, then an immediate back-to-back operation
    @(posedge clk); #2;
    out_ready = 1'b0;
    applyStimulus(OP_DIVU, 32'd1000, 32'd10);
    waitResult("bp", lat);
    held = div_result;
    checkOutput("bp_result", held, 32'd100);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      checkOutput("bp_stable", div_result, held);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #2;
    checkOutput("bp_ready_after", 32'(in_ready), 32'd1);
    runOp("b2b_div", OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, LAT_NORMAL);

    // Flush at edge 10 of a running DIVU
    @(posedge clk); #2;
    applyStimulus(OP_DIVU, $urandom, 32'd3);
    repeat (9) begin
      @(posedge clk); #2;
    end
    flush = 1'b1;
    @(posedge clk); #2;
    flush = 1'b0;
    checkOutput("flush_busy", 32'(busy), 32'd0);
    checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #2;
      seen |= out_valid;
    end
    checkOutput("flush_no_valid", 32'(seen), 32'd0);
    runOp("after_flush", OP_DIVU, 32'd9, 32'd3, 32'd3, LAT_NORMAL);

    // Reset at edge 12 of a running DIVU
    @(posedge clk); #2;
    applyStimulus(OP_DIVU, $urandom, $urandom | 32'd1);
    repeat (11) begin
      @(posedge clk); #2;
    end
    rst_n = 1'b0;
    @(posedge clk); #2;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_div_result", div_result, 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1;
    checkOutput("rst_release_ready", 32'(in_ready), 32'd1);

    // Randomized traffic with random backpressure, occasional flush and reset
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #2;
      rst_n     = ($urandom_range(0, 499) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      in_valid  = $urandom_range(0, 1) != 0;
      out_ready = ($urandom_range(0, 3) != 0);
      div_op    = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0: begin in_lhs = $urandom; in_rhs = '0; end
        1: begin in_lhs = 32'h8000_0000; in_rhs = 32'hFFFF_FFFF; end
        2: begin in_lhs = 32'($urandom_range(0, 255)); in_rhs = 32'($urandom_range(1, 15)); end
        3: begin in_lhs = $urandom; in_rhs = 32'hFFFF_FFFF - 32'($urandom_range(0, 3)); end
        default: begin in_lhs = $urandom; in_rhs = $urandom >> $urandom_range(0, 31); end
      endcase
    end
    @(posedge clk); #2;
    rst_n     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
